// File: rtl/noc_packet_sink_pkg.sv
// Shared types for the packet sink: parser state encoding and header field widths.
package noc_packet_sink_pkg;

    localparam int TARGET_W = 16;

    typedef enum logic [1:0] {
        ST_HEAD,
        ST_SIZE,
        ST_HDR,
        ST_PLD
    } state_e;

endpackage

// File: rtl/noc_flit_fifo.sv
// Flit buffer: power-of-two ring with naturally wrapping pointers and an explicit occupancy count.
module noc_flit_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         data_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         head_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   occ_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      occ_q, occ_d;
    logic             push_ok, pop_ok;

    assign full_o  = (occ_q == (AW+1)'(DEPTH));
    assign empty_o = (occ_q == '0);
    assign occ_o   = occ_q;
    assign head_o  = mem_q[rd_ptr_q];

    // Guard here too so a misbehaving caller cannot corrupt the pointers.
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;

    always_comb begin
        occ_d = occ_q;
        if (push_ok && !pop_ok)
            occ_d = occ_q + 1'b1;
        else if (!push_ok && pop_ok)
            occ_d = occ_q - 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (push_ok)
            mem_q[wr_ptr_q] <= data_i;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
        end else begin
            if (push_ok)
                wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_ok)
                rd_ptr_q <= rd_ptr_q + 1'b1;
            occ_q <= occ_d;
        end
    end

endmodule

// File: rtl/noc_packet_sink.sv
// Receiving end of the credit-based flit link: buffers flits, parses header and size,
// then streams the payload to a valid/ready consumer.
module noc_packet_sink
    import noc_packet_sink_pkg::*;
#(
    parameter int FLIT_SIZE    = 32,
    parameter int BUFFER_DEPTH = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 rx_i,
    output logic                 credit_o,
    input  logic [FLIT_SIZE-1:0] data_i,
    output logic                 hdr_valid_o,
    input  logic                 hdr_ready_i,
    output logic [TARGET_W-1:0]  hdr_target_o,
    output logic [FLIT_SIZE-1:0] hdr_size_o,
    output logic                 pld_valid_o,
    input  logic                 pld_ready_i,
    output logic [FLIT_SIZE-1:0] pld_data_o,
    output logic                 pld_last_o,
    output logic [31:0]          pkt_count_o,
    output logic                 overflow_o
);

    localparam int OCC_W = $clog2(BUFFER_DEPTH) + 1;

    state_e                 state_q;
    logic [TARGET_W-1:0]    target_q;
    logic [FLIT_SIZE-1:0]   size_q, remaining_q;
    logic [31:0]            pkt_count_q;
    logic                   overflow_q, hdr_valid_q;

    logic                   fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [FLIT_SIZE-1:0]   fifo_head;
    logic [OCC_W-1:0]       fifo_occ;

    noc_flit_fifo #(
        .WIDTH (FLIT_SIZE),
        .DEPTH (BUFFER_DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (fifo_push),
        .data_i  (data_i),
        .pop_i   (fifo_pop),
        .head_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .occ_o   (fifo_occ)
    );

    // Credit comes from registered occupancy only, so a same-cycle pop never raises it early.
    assign credit_o  = (fifo_occ != OCC_W'(BUFFER_DEPTH));
    assign fifo_push = rx_i && credit_o;

    assign pld_valid_o = (state_q == ST_PLD) && !fifo_empty;
    assign pld_data_o  = pld_valid_o ? fifo_head : '0;
    assign pld_last_o  = pld_valid_o && (remaining_q == FLIT_SIZE'(1));

    always_comb begin
        fifo_pop = 1'b0;
        case (state_q)
            ST_HEAD, ST_SIZE: fifo_pop = !fifo_empty;
            ST_PLD:           fifo_pop = pld_valid_o && pld_ready_i;
            default:          fifo_pop = 1'b0;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_HEAD;
            target_q    <= '0;
            size_q      <= '0;
            remaining_q <= '0;
            pkt_count_q <= '0;
            overflow_q  <= 1'b0;
            hdr_valid_q <= 1'b0;
        end else begin
            if (rx_i && fifo_full)
                overflow_q <= 1'b1;
            case (state_q)
                ST_HEAD: begin
                    if (!fifo_empty) begin
                        target_q <= fifo_head[TARGET_W-1:0];
                        state_q  <= ST_SIZE;
                    end
                end
                ST_SIZE: begin
                    if (!fifo_empty) begin
                        size_q      <= fifo_head;
                        remaining_q <= fifo_head;
                        hdr_valid_q <= 1'b1;
                        state_q     <= ST_HDR;
                    end
                end
                ST_HDR: begin
                    if (hdr_ready_i) begin
                        hdr_valid_q <= 1'b0;
                        if (size_q == '0) begin
                            pkt_count_q <= pkt_count_q + 32'd1;
                            state_q     <= ST_HEAD;
                        end else begin
                            state_q <= ST_PLD;
                        end
                    end
                end
                ST_PLD: begin
                    if (pld_valid_o && pld_ready_i) begin
                        remaining_q <= remaining_q - 1'b1;
                        if (remaining_q == FLIT_SIZE'(1)) begin
                            pkt_count_q <= pkt_count_q + 32'd1;
                            state_q     <= ST_HEAD;
                        end
                    end
                end
                default: state_q <= ST_HEAD;
            endcase
        end
    end

    assign hdr_valid_o  = hdr_valid_q;
    assign hdr_target_o = target_q;
    assign hdr_size_o   = size_q;
    assign pkt_count_o  = pkt_count_q;
    assign overflow_o   = overflow_q;

endmodule

// File: tb/tb_noc_packet_sink.sv
// Bench for noc_packet_sink: queue-based reference model checked every cycle, plus directed literal checks.
module tb_noc_packet_sink;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        rx_i;
    logic        credit_o;
    logic [31:0] data_i;
    logic        hdr_valid_o;
    logic        hdr_ready_i;
    logic [15:0] hdr_target_o;
    logic [31:0] hdr_size_o;
    logic        pld_valid_o;
    logic        pld_ready_i;
    logic [31:0] pld_data_o;
    logic        pld_last_o;
    logic [31:0] pkt_count_o;
    logic        overflow_o;

    noc_packet_sink #(.FLIT_SIZE(32), .BUFFER_DEPTH(4)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .rx_i         (rx_i),
        .credit_o     (credit_o),
        .data_i       (data_i),
        .hdr_valid_o  (hdr_valid_o),
        .hdr_ready_i  (hdr_ready_i),
        .hdr_target_o (hdr_target_o),
        .hdr_size_o   (hdr_size_o),
        .pld_valid_o  (pld_valid_o),
        .pld_ready_i  (pld_ready_i),
        .pld_data_o   (pld_data_o),
        .pld_last_o   (pld_last_o),
        .pkt_count_o  (pkt_count_o),
        .overflow_o   (overflow_o)
    );

    always #5 clk_i = ~clk_i;

    int n_cmp = 0;
    int n_err = 0;
    bit rand_mode = 0;
    bit viol_made = 0;

    // Reference model: buffer contents as a queue, position within the current packet,
    // and whether the header has been handed over yet.
    logic [31:0] mq[$];
    int          m_pos;
    bit          m_hacked;
    logic [15:0] m_tgt;
    logic [31:0] m_size;
    logic [31:0] m_pkt;
    bit          m_ovf;

    logic [31:0] obs_pld[$];
    bit          obs_last[$];
    logic [15:0] obs_tgt[$];
    logic [31:0] obs_size[$];
    int          n_hv = 0;
    int          n_pv = 0;
    logic [31:0] exp_q[$];

    bit          e_hv, e_pv, e_credit;
    logic [31:0] e_rem, f;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk_i) begin
        if (rst_i) begin
            mq.delete();
            m_pos = 0; m_hacked = 0; m_tgt = '0; m_size = '0; m_pkt = '0; m_ovf = 0;
        end else begin
            e_credit = (mq.size() != 4);
            e_hv     = (m_pos == 2) && !m_hacked;
            e_pv     = (m_pos >= 2) && m_hacked && (mq.size() > 0);
            e_rem    = m_size - 32'(m_pos - 2);
            check("credit", credit_o, e_credit);
            check("hdr_valid", hdr_valid_o, e_hv);
            check("pld_valid", pld_valid_o, e_pv);
            check("pld_last", pld_last_o, e_pv && (e_rem == 1));
            check("pkt_count", pkt_count_o, m_pkt);
            check("overflow", overflow_o, m_ovf);
            if (e_hv) begin
                check("hdr_target", hdr_target_o, m_tgt);
                check("hdr_size", hdr_size_o, m_size);
            end
            if (e_pv) check("pld_data", pld_data_o, mq[0]);
            if (hdr_valid_o) n_hv++;
            if (pld_valid_o) n_pv++;

            if (m_pos < 2 && mq.size() > 0) begin
                f = mq.pop_front();
                if (m_pos == 0) m_tgt = f[15:0];
                else begin m_size = f; m_hacked = 0; end
                m_pos++;
            end else if (e_hv && hdr_ready_i) begin
                obs_tgt.push_back(hdr_target_o);
                obs_size.push_back(hdr_size_o);
                if (m_size == 0) begin m_pkt++; m_pos = 0; end
                else m_hacked = 1;
            end else if (e_pv && pld_ready_i) begin
                obs_pld.push_back(pld_data_o);
                obs_last.push_back(pld_last_o);
                void'(mq.pop_front());
                if (e_rem == 1) begin m_pkt++; m_pos = 0; end
                else m_pos++;
            end
            if (rx_i) begin
                if (e_credit) mq.push_back(data_i);
                else m_ovf = 1;
            end
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
        if (rand_mode) begin
            hdr_ready_i = ($urandom_range(0, 3) != 0);
            pld_ready_i = ($urandom_range(0, 3) != 0);
        end
    endtask

    task automatic send(input logic [31:0] d);
        int t;
        t = 0;
        if (rand_mode) repeat ($urandom_range(0, 2)) tick();
        while (!credit_o && t < 300) begin
            if (rand_mode && $urandom_range(0, 9) == 0) begin
                rx_i = 1'b1; data_i = $urandom; viol_made = 1;
            end
            tick();
            rx_i = 1'b0; data_i = 'x;
            t++;
        end
        if (t >= 300) check("send_credit_timeout", credit_o, 1);
        rx_i = 1'b1; data_i = d;
        tick();
        rx_i = 1'b0; data_i = 'x;
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while ((mq.size() != 0 || m_pos != 0) && t < 500) begin tick(); t++; end
        if (t >= 500) check("idle_timeout", 32'(mq.size() + m_pos), 0);
        tick();
    endtask

    task automatic check_seq(input string nm);
        check({nm, "_len"}, 64'(obs_pld.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < obs_pld.size(); i++) begin
            check(nm, obs_pld[i], exp_q[i]);
            check({nm, "_last"}, obs_last[i], (i == exp_q.size() - 1));
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_credit"}, credit_o, 1);
        check({tag, "_hdr_valid"}, hdr_valid_o, 0);
        check({tag, "_pld_valid"}, pld_valid_o, 0);
        check({tag, "_pld_last"}, pld_last_o, 0);
        check({tag, "_pkt_count"}, pkt_count_o, 0);
        check({tag, "_overflow"}, overflow_o, 0);
        check({tag, "_hdr_target"}, hdr_target_o, 0);
        check({tag, "_hdr_size"}, hdr_size_o, 0);
        check({tag, "_pld_data"}, pld_data_o, 0);
    endtask

    initial begin
        int hv0, pv0, t;
        rst_i = 1'b1; rx_i = 1'b0; data_i = 'x; hdr_ready_i = 1'b0; pld_ready_i = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        check_reset_outputs("reset");

        // Single packet, consumer always ready.
        hdr_ready_i = 1'b1; pld_ready_i = 1'b1;
        send(32'h0000_0102); send(32'd3);
        send(32'hAAAA_0001); send(32'hBBBB_0002); send(32'hCCCC_0003);
        wait_idle();
        check("single_tgt_n", 64'(obs_tgt.size()), 1);
        if (obs_tgt.size() > 0) begin
            check("single_tgt", obs_tgt[0], 16'h0102);
            check("single_size", obs_size[0], 32'd3);
        end
        exp_q = '{32'hAAAA_0001, 32'hBBBB_0002, 32'hCCCC_0003};
        check_seq("single_pld");
        check("single_pkt", pkt_count_o, 1);

        // Zero-size packet.
        obs_pld.delete(); obs_last.delete(); obs_tgt.delete(); obs_size.delete();
        hv0 = n_hv; pv0 = n_pv;
        send(32'h0000_0201); send(32'd0);
        wait_idle();
        check("zero_hv_cycles", 32'(n_hv - hv0), 1);
        check("zero_pv_cycles", 32'(n_pv - pv0), 0);
        check("zero_pkt", pkt_count_o, 2);
        if (obs_tgt.size() > 0) check("zero_tgt", obs_tgt[0], 16'h0201);

        // Backpressure: 6 flits with payload consumer stalled.
        obs_pld.delete(); obs_last.delete();
        pld_ready_i = 1'b0;
        send(32'h0000_0305); send(32'd4);
        send(32'hD000_0000); send(32'hD000_0001); send(32'hD000_0002); send(32'hD000_0003);
        check("bp_credit_low", credit_o, 0);
        check("bp_pld_valid", pld_valid_o, 1);
        check("bp_overflow_clear", overflow_o, 0);

        // Violation during a pop-only cycle: flit dropped, credit back one cycle later.
        rx_i = 1'b1; data_i = 32'hBAD0_BAD0; pld_ready_i = 1'b1;
        tick();
        rx_i = 1'b0; data_i = 'x; pld_ready_i = 1'b0;
        check("viol_overflow", overflow_o, 1);
        check("viol_credit_back", credit_o, 1);
        repeat (3) tick();
        check("viol_sticky", overflow_o, 1);
        pld_ready_i = 1'b1;
        wait_idle();
        exp_q = '{32'hD000_0000, 32'hD000_0001, 32'hD000_0002, 32'hD000_0003};
        check_seq("bp_pld");
        check("bp_pkt", pkt_count_o, 3);
        check("bp_sticky_end", overflow_o, 1);

        // Reset after 2 of 5 payload flits.
        obs_pld.delete(); obs_last.delete();
        pld_ready_i = 1'b0;
        send(32'h0000_0606); send(32'd5);
        send(32'hE000_0000); send(32'hE000_0001); send(32'hE000_0002);
        pld_ready_i = 1'b1;
        t = 0;
        while (m_pos != 4 && t < 50) begin tick(); t++; end
        if (t >= 50) check("mid_reset_timeout", 32'(m_pos), 4);
        pld_ready_i = 1'b0;
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        check_reset_outputs("mid_reset");
        obs_pld.delete(); obs_last.delete();
        hdr_ready_i = 1'b1; pld_ready_i = 1'b1;
        send(32'h0000_0707); send(32'd1); send(32'hF00D_0001);
        wait_idle();
        exp_q = '{32'hF00D_0001};
        check_seq("fresh_pld");
        check("fresh_pkt", pkt_count_o, 1);

        // Randomized packets, consumer stalls and occasional protocol violations.
        rand_mode = 1;
        for (int p = 0; p < 40; p++) begin
            int sz;
            sz = $urandom_range(0, 5);
            send($urandom);
            send(32'(sz));
            for (int k = 0; k < sz; k++) send($urandom);
        end
        wait_idle();
        check("rand_pkt", pkt_count_o, 41);
        check("rand_overflow", overflow_o, viol_made);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #800000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1);
    end

endmodule
